// File: rtl/spi_pkg.sv
// Shared SPI definitions for the AES link: master FSM states and bus-mode constants.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL
  } spi_state_t;

  localparam logic SPI_CPOL    = 1'b0;
  localparam logic SPI_CPHA    = 1'b0;
  localparam int   AES_BLOCK_W = 128;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider: one-cycle tick every CLK_DIV clocks while enabled, cleared when idle.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick = en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset || !en || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 full-duplex SPI master moving one DATA_WIDTH-bit word per start pulse.
// Every bus output is registered from the current state, so pins trail the FSM by one clock.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = AES_BLOCK_W,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  MISO,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  CS,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH);

  spi_state_t state, state_nxt;
  logic                  tick;
  logic                  div_en;
  logic                  trail_half;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      bit_inc;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  sclk_nxt, mosi_nxt, cs_nxt, busy_nxt, done_nxt, capture;

  assign div_en  = (state != IDLE);
  assign bit_inc = bit_cnt + CNT_W'(1);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk   (clk),
    .reset (reset),
    .en    (div_en),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // TRAIL spans a full sclk-low half period plus the CS hold time before releasing the bus.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = LEAD;
      LEAD, LOW: if (tick) state_nxt = HIGH;
      HIGH:      if (tick) state_nxt = (bit_inc < LAST_BIT) ? LOW : TRAIL;
      TRAIL:     if (tick && trail_half) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cs_nxt   = (state == IDLE);
    busy_nxt = (state != IDLE);
    sclk_nxt = (state == HIGH) ^ SPI_CPOL;
    mosi_nxt = (state != IDLE) && tx_shift[DATA_WIDTH-1];
    done_nxt = (state == IDLE) && !CS;
    capture  = (state == HIGH) && (sclk == SPI_CPOL);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk       <= SPI_CPOL;
      mosi       <= 1'b0;
      CS         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      rx_data    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      trail_half <= 1'b0;
    end else begin
      sclk <= sclk_nxt;
      mosi <= mosi_nxt;
      CS   <= cs_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
      if (state == IDLE) begin
        bit_cnt    <= '0;
        trail_half <= 1'b0;
        if (start) tx_shift <= tx_data;
      end
      if (state == HIGH && tick) begin
        bit_cnt <= bit_inc;
        if (bit_inc < LAST_BIT) tx_shift <= tx_shift << 1;
      end
      if (state == TRAIL && tick) trail_half <= 1'b1;
      if (capture) rx_shift <= (rx_shift << 1) | DATA_WIDTH'(MISO);
      if (done_nxt) rx_data <= rx_shift;
    end
  end

endmodule
